// File: rtl/grid_renderer.sv
// Three-stage play-field pixel generator: grid tiles with cook-timer bars plus
// up to NUM_PLAYERS player squares, with syncs delayed to match the pixel.
module grid_renderer #(
    parameter int GRID_COLS   = 13,
    parameter int GRID_ROWS   = 8,
    parameter int TILE_LOG2   = 5,
    parameter int ORIGIN_X    = 112,
    parameter int ORIGIN_Y    = 112,
    parameter int NUM_PLAYERS = 4,
    parameter int PLAYER_SIZE = 16,
    parameter int S_GAME      = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [2:0]                       game_state,
    input  logic [1:0]                       local_player_ID,
    input  logic [2:0]                       num_players,
    input  logic [GRID_ROWS*GRID_COLS*4-1:0] object_grid,
    input  logic [GRID_ROWS*GRID_COLS*4-1:0] time_grid,
    input  logic [NUM_PLAYERS*9-1:0]         player_x,
    input  logic [NUM_PLAYERS*9-1:0]         player_y,
    input  logic [NUM_PLAYERS*2-1:0]         player_direction,
    input  logic [10:0]                      hcount,
    input  logic [9:0]                       vcount,
    input  logic                             hsync,
    input  logic                             vsync,
    input  logic                             blank,
    output logic                             hsync_out,
    output logic                             vsync_out,
    output logic                             blank_out,
    output logic [11:0]                      pixel_out
);
    localparam int CELLS  = GRID_ROWS * GRID_COLS;
    localparam int IDX_W  = $clog2(CELLS);
    localparam int CW     = 12 - TILE_LOG2;

    function automatic logic [11:0] palette(input logic [3:0] code);
        case (code)
            4'd0:    palette = 12'h666;
            4'd1:    palette = 12'hC6F;
            4'd2:    palette = 12'hE9F;
            4'd3:    palette = 12'hFFF;
            4'd4:    palette = 12'hFA4;
            4'd5:    palette = 12'h444;
            4'd6:    palette = 12'hA86;
            4'd7:    palette = 12'hA40;
            4'd8:    palette = 12'hF80;
            4'd9:    palette = 12'hF00;
            4'd10:   palette = 12'hD22;
            default: palette = 12'hF0F;
        endcase
    endfunction

    logic                   vs_prev_r;
    logic [CELLS*4-1:0]     shadow_obj_r;
    logic [CELLS*4-1:0]     shadow_time_r;

    logic signed [11:0]     dx_s, dy_s;
    logic [CW-1:0]          col_s, row_s;
    logic                   in_grid_s;
    logic [IDX_W-1:0]       idx_s;

    logic signed [11:0]     dx1_r, dy1_r;
    logic [TILE_LOG2-1:0]   ox1_r, oy1_r;
    logic [IDX_W-1:0]       idx1_r;
    logic                   in_grid1_r, hs1_r, vs1_r, bl1_r;
    logic [2:0]             gs1_r;

    logic [3:0]             code_s, time_s;
    logic [TILE_LOG2:0]     bar_s;
    logic [11:0]            tile_s, pcol_s;
    logic                   hit_s, phit_s, strip_s;
    logic signed [11:0]     ux_s, uy_s;

    logic [11:0]            tile2_r, pcol2_r;
    logic                   hit2_r, in_grid2_r, hs2_r, vs2_r, bl2_r;
    logic [2:0]             gs2_r;
    logic [11:0]            px3_s;

    // Frame latch: snapshot the grids on the vsync falling edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vs_prev_r     <= 1'b0;
            shadow_obj_r  <= {(CELLS*4){1'b0}};
            shadow_time_r <= {(CELLS*4){1'b0}};
        end else begin
            vs_prev_r <= vsync;
            if (vs_prev_r && !vsync) begin
                shadow_obj_r  <= object_grid;
                shadow_time_r <= time_grid;
            end
        end
    end

    // Stage 1 combinational: grid-relative coordinates and cell index.
    always_comb begin
        dx_s      = $signed({1'b0, hcount}) - $signed(12'(ORIGIN_X));
        dy_s      = $signed({2'b00, vcount}) - $signed(12'(ORIGIN_Y));
        col_s     = dx_s[11:TILE_LOG2];
        row_s     = dy_s[11:TILE_LOG2];
        in_grid_s = !dx_s[11] && !dy_s[11] &&
                    (int'(col_s) < GRID_COLS) && (int'(row_s) < GRID_ROWS);
        if (in_grid_s) begin
            idx_s = IDX_W'(int'(row_s) * GRID_COLS + int'(col_s));
        end else begin
            idx_s = {IDX_W{1'b0}};
        end
    end

    // Stage 2 combinational: tile shading and player compositing.
    always_comb begin
        code_s  = shadow_obj_r[{idx1_r, 2'b00} +: 4];
        time_s  = shadow_time_r[{idx1_r, 2'b00} +: 4];
        bar_s   = (TILE_LOG2 + 1)'(time_s) << (TILE_LOG2 - 4);
        if (ox1_r == {TILE_LOG2{1'b0}} || oy1_r == {TILE_LOG2{1'b0}}) begin
            tile_s = 12'h000;
        end else if (time_s != 4'd0 && oy1_r >= TILE_LOG2'((1 << TILE_LOG2) - 4) &&
                     {1'b0, ox1_r} < bar_s) begin
            tile_s = 12'h0F0;
        end else begin
            tile_s = palette(code_s);
        end

        hit_s   = 1'b0;
        pcol_s  = 12'h000;
        phit_s  = 1'b0;
        strip_s = 1'b0;
        ux_s    = 12'sd0;
        uy_s    = 12'sd0;
        // Walk from the highest slot down so the lowest index wins overlaps.
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            ux_s = dx1_r - $signed({3'b000, player_x[i*9 +: 9]});
            uy_s = dy1_r - $signed({3'b000, player_y[i*9 +: 9]});
            case (player_direction[i*2 +: 2])
                2'd0:    strip_s = ux_s < 12'sd4;
                2'd1:    strip_s = ux_s >= $signed(12'(PLAYER_SIZE - 4));
                2'd2:    strip_s = uy_s < 12'sd4;
                2'd3:    strip_s = uy_s >= $signed(12'(PLAYER_SIZE - 4));
                default: strip_s = 1'b0;
            endcase
            phit_s = (i < int'(num_players)) &&
                     ux_s >= 12'sd0 && ux_s < $signed(12'(PLAYER_SIZE)) &&
                     uy_s >= 12'sd0 && uy_s < $signed(12'(PLAYER_SIZE));
            hit_s  = hit_s | phit_s;
            pcol_s = !phit_s ? pcol_s :
                     strip_s ? 12'hF00 :
                     (i == int'(local_player_ID)) ? 12'hFF0 : 12'h0AF;
        end
    end

    // Stage 3 combinational: final priority select.
    always_comb begin
        if (bl2_r) begin
            px3_s = 12'h000;
        end else if (gs2_r != 3'(S_GAME)) begin
            px3_s = 12'h000;
        end else if (hit2_r) begin
            px3_s = pcol2_r;
        end else if (in_grid2_r) begin
            px3_s = tile2_r;
        end else begin
            px3_s = 12'h224;
        end
    end

    // Pipeline registers for all three stages.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dx1_r      <= 12'sd0;
            dy1_r      <= 12'sd0;
            ox1_r      <= {TILE_LOG2{1'b0}};
            oy1_r      <= {TILE_LOG2{1'b0}};
            idx1_r     <= {IDX_W{1'b0}};
            in_grid1_r <= 1'b0;
            hs1_r      <= 1'b1;
            vs1_r      <= 1'b1;
            bl1_r      <= 1'b1;
            gs1_r      <= 3'd0;
            tile2_r    <= 12'h000;
            pcol2_r    <= 12'h000;
            hit2_r     <= 1'b0;
            in_grid2_r <= 1'b0;
            hs2_r      <= 1'b1;
            vs2_r      <= 1'b1;
            bl2_r      <= 1'b1;
            gs2_r      <= 3'd0;
            pixel_out  <= 12'h000;
            hsync_out  <= 1'b1;
            vsync_out  <= 1'b1;
            blank_out  <= 1'b1;
        end else begin
            dx1_r      <= dx_s;
            dy1_r      <= dy_s;
            ox1_r      <= dx_s[TILE_LOG2-1:0];
            oy1_r      <= dy_s[TILE_LOG2-1:0];
            idx1_r     <= idx_s;
            in_grid1_r <= in_grid_s;
            hs1_r      <= hsync;
            vs1_r      <= vsync;
            bl1_r      <= blank;
            gs1_r      <= game_state;
            tile2_r    <= tile_s;
            pcol2_r    <= pcol_s;
            hit2_r     <= hit_s;
            in_grid2_r <= in_grid1_r;
            hs2_r      <= hs1_r;
            vs2_r      <= vs1_r;
            bl2_r      <= bl1_r;
            gs2_r      <= gs1_r;
            pixel_out  <= px3_s;
            hsync_out  <= hs2_r;
            vsync_out  <= vs2_r;
            blank_out  <= bl2_r;
        end
    end
endmodule

// File: tb/tb_grid_renderer.sv
// Scoreboard bench for grid_renderer: directed cases plus randomized pixels
// checked against a coordinate-level reference model.
module tb_grid_renderer;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   game_state;
    logic [1:0]   local_player_ID;
    logic [2:0]   num_players;
    logic [415:0] object_grid, time_grid;
    logic [35:0]  player_x, player_y;
    logic [7:0]   player_direction;
    logic [10:0]  hcount;
    logic [9:0]   vcount;
    logic         hsync, vsync, blank;
    logic         hsync_out, vsync_out, blank_out;
    logic [11:0]  pixel_out;

    grid_renderer dut (
        .clock(clock), .reset(reset), .game_state(game_state),
        .local_player_ID(local_player_ID), .num_players(num_players),
        .object_grid(object_grid), .time_grid(time_grid),
        .player_x(player_x), .player_y(player_y),
        .player_direction(player_direction),
        .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
        .pixel_out(pixel_out)
    );

    always #5 clock = ~clock;

    typedef struct { logic [11:0] px; logic [2:0] tm; int id; } exp_t;
    exp_t q[$];
    exp_t e;
    int passed = 0;
    int total  = 0;
    int nid    = 0;
    logic issue = 1'b0;
    logic v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;

    logic [11:0] pal [16] = '{12'h666, 12'hC6F, 12'hE9F, 12'hFFF, 12'hFA4, 12'h444,
                             12'hA86, 12'hA40, 12'hF80, 12'hF00, 12'hD22, 12'hF0F,
                             12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F};
    int obj_in [8][13];
    int tim_in [8][13];
    int sh_obj [8][13];
    int sh_tim [8][13];
    int px [4];
    int py [4];
    int pd [4];
    int n_act = 0, local_id = 0, gs = 1;
    bit prev_vs = 1'b0;

    task automatic check(input string nm, input int id, input logic [11:0] act, input logic [11:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s #%0d: got %h, expected %h", nm, id, act, want);
    endtask

    function automatic logic [11:0] model_px(input int h, input int v, input bit bl, input int g);
        int x, y, ux, uy, r, c, ox, oy;
        if (bl || g != 1) return 12'h000;
        x = h - 112;
        y = v - 112;
        for (int i = 0; i < 4 && i < n_act; i++) begin
            ux = x - px[i];
            uy = y - py[i];
            if (ux >= 0 && ux < 16 && uy >= 0 && uy < 16) begin
                if ((pd[i] == 0 && ux < 4) || (pd[i] == 1 && ux >= 12) ||
                    (pd[i] == 2 && uy < 4) || (pd[i] == 3 && uy >= 12)) return 12'hF00;
                return (i == local_id) ? 12'hFF0 : 12'h0AF;
            end
        end
        if (x < 0 || y < 0 || x >= 13 * 32 || y >= 8 * 32) return 12'h224;
        c = x / 32; r = y / 32; ox = x % 32; oy = y % 32;
        if (ox == 0 || oy == 0) return 12'h000;
        if (sh_tim[r][c] != 0 && oy >= 28 && ox < sh_tim[r][c] * 2) return 12'h0F0;
        return pal[sh_obj[r][c]];
    endfunction

    task automatic apply_grid();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 13; c++) begin
                object_grid[(r*13+c)*4 +: 4] = 4'(obj_in[r][c]);
                time_grid[(r*13+c)*4 +: 4]   = 4'(tim_in[r][c]);
            end
    endtask

    task automatic apply_players();
        for (int i = 0; i < 4; i++) begin
            player_x[i*9 +: 9]         = 9'(px[i]);
            player_y[i*9 +: 9]         = 9'(py[i]);
            player_direction[i*2 +: 2] = 2'(pd[i]);
        end
        num_players     = 3'(n_act);
        local_player_ID = 2'(local_id);
    endtask

    // Drive one pixel and queue its expected output (want < 0 -> use model).
    task automatic put(input int h, input int v, input bit hs, input bit vs, input bit bl, input int want);
        exp_t x;
        if (prev_vs && !vs) begin
            sh_obj = obj_in;
            sh_tim = tim_in;
        end
        prev_vs = vs;
        hcount = 11'(h); vcount = 10'(v);
        hsync = hs; vsync = vs; blank = bl;
        game_state = 3'(gs);
        x.px = (want < 0) ? model_px(h, v, bl, gs) : 12'(want);
        x.tm = {hs, vs, bl};
        x.id = nid++;
        q.push_back(x);
        issue = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        issue = 1'b0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic latch();
        put(0, 0, 1'b1, 1'b0, 1'b1, 0);
        put(0, 0, 1'b1, 1'b1, 1'b1, 0);
    endtask

    always @(posedge clock) begin
        v1 <= issue; v2 <= v1; v3 <= v2;
    end

    // Monitor: one queued expectation per issued pixel, three clocks later.
    always @(negedge clock) begin
        if (v3) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL underflow: got output with no expectation, expected queue entry");
            end else begin
                e = q.pop_front();
                check("pixel", e.id, pixel_out, e.px);
                check("timing", e.id, {9'b0, hsync_out, vsync_out, blank_out}, {9'b0, e.tm});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        game_state = 3'd1; hcount = 11'd0; vcount = 10'd0;
        hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
        object_grid = '0; time_grid = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 13; c++) begin
                obj_in[r][c] = $urandom_range(15, 0);
                tim_in[r][c] = $urandom_range(15, 0);
                sh_obj[r][c] = 0;
                sh_tim[r][c] = 0;
            end
        obj_in[1][2] = 1; tim_in[1][2] = 0;
        obj_in[1][1] = 4; tim_in[1][1] = 0;
        tim_in[0][0] = 8;
        for (int i = 0; i < 4; i++) begin px[i] = 0; py[i] = 0; pd[i] = 0; end
        n_act = 0; local_id = 0;
        apply_grid();
        apply_players();

        #3 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_pixel", 0, pixel_out, 12'h000);
        check("rst_hsync", 0, {11'b0, hsync_out}, 12'h001);
        check("rst_vsync", 0, {11'b0, vsync_out}, 12'h001);
        check("rst_blank", 0, {11'b0, blank_out}, 12'h001);
        reset = 1'b1;
        prev_vs = 1'b0;
        @(posedge clock); #1;

        put(181, 149, 1'b1, 1'b1, 1'b0, 12'h666);
        latch();
        put(181, 149, 1'b1, 1'b1, 1'b0, 12'hC6F);
        put(176, 149, 1'b1, 1'b1, 1'b0, 12'h000);
        put(111, 149, 1'b0, 1'b1, 1'b0, 12'h224);
        put(127, 142, 1'b1, 1'b1, 1'b0, 12'h0F0);
        put(128, 142, 1'b1, 1'b1, 1'b0, -1);
        put(181, 174, 1'b1, 1'b1, 1'b0, 12'hC6F);

        obj_in[1][2] = 9;
        apply_grid();
        put(181, 149, 1'b1, 1'b1, 1'b0, 12'hC6F);
        latch();
        put(181, 149, 1'b0, 1'b1, 1'b0, 12'hF00);

        idle(4);
        reset = 1'b0;
        #1;
        check("midrst_pixel", 1, pixel_out, 12'h000);
        check("midrst_hsync", 1, {11'b0, hsync_out}, 12'h001);
        check("midrst_vsync", 1, {11'b0, vsync_out}, 12'h001);
        check("midrst_blank", 1, {11'b0, blank_out}, 12'h001);
        @(posedge clock); #2;
        reset = 1'b1;
        prev_vs = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 13; c++) begin sh_obj[r][c] = 0; sh_tim[r][c] = 0; end
        @(posedge clock); #1;
        put(181, 149, 1'b1, 1'b1, 1'b0, 12'h666);
        latch();

        idle(4);
        n_act = 2; local_id = 1;
        px[0] = 0;  py[0] = 0;  pd[0] = 1;
        px[1] = 0;  py[1] = 0;  pd[1] = 1;
        px[2] = 40; py[2] = 40; pd[2] = 0;
        px[3] = 300; py[3] = 200; pd[3] = 2;
        apply_players();
        put(117, 117, 1'b1, 1'b1, 1'b0, 12'h0AF);
        put(126, 117, 1'b1, 1'b1, 1'b0, 12'hF00);
        put(157, 157, 1'b1, 1'b1, 1'b0, 12'hFA4);

        put(181, 149, 1'b1, 1'b1, 1'b1, 12'h000);
        gs = 0;
        put(181, 149, 1'b0, 1'b0, 1'b0, 12'h000);
        gs = 1;
        put(181, 149, 1'b1, 1'b1, 1'b0, 12'hF00);

        for (int b = 0; b < 30; b++) begin
            idle(4);
            n_act = $urandom_range(5, 0);
            local_id = $urandom_range(3, 0);
            for (int i = 0; i < 4; i++) begin
                px[i] = $urandom_range(450, 0);
                py[i] = $urandom_range(280, 0);
                pd[i] = $urandom_range(3, 0);
            end
            apply_players();
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 13; c++) begin
                    obj_in[r][c] = $urandom_range(15, 0);
                    tim_in[r][c] = ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(15, 1);
                end
            apply_grid();
            for (int k = 0; k < 40; k++) begin
                gs = ($urandom_range(15, 0) == 0) ? 0 : 1;
                put($urandom_range(560, 90), $urandom_range(380, 90),
                    1'($urandom_range(1, 0)), ($urandom_range(19, 0) != 0),
                    ($urandom_range(7, 0) == 0), -1);
            end
        end

        idle(6);
        check("queue_drained", 2, 12'(q.size()), 12'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/grid_renderer.md
Name: grid_renderer

Overview:
Parametrised, pipelined pixel generator for the kitchen play-field. It maps XVGA hcount/vcount to a grid cell and looks up that cell's object code and cook timer from a frame-stable shadow copy. It then draws a tile (fill, border, timer bar), composites up to NUM_PLAYERS player squares on top, and emits the pixel with syncs delayed to match. It sits between the game-state logic and the VGA output stage, replacing the single-player, unpipelined path.

Parameters:
GRID_COLS, 13, grid columns
GRID_ROWS, 8, grid rows
TILE_LOG2, 5, log2 of tile edge in pixels (32)
ORIGIN_X, 112, pixel x of grid column 0
ORIGIN_Y, 112, pixel y of grid row 0
NUM_PLAYERS, 4, player slots (1..4)
PLAYER_SIZE, 16, player square edge in pixels
S_GAME, 1, game_state value that enables grid/player drawing

Ports:
clock  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
game_state  in  3  current game mode
local_player_ID  in  2  index of this console's player
num_players  in  3  active player count; slots >= num_players not drawn
object_grid  in  GRID_ROWS*GRID_COLS*4  cell code at bits [(r*GRID_COLS+c)*4 +: 4]
time_grid  in  GRID_ROWS*GRID_COLS*4  cell timer, same packing
player_x  in  NUM_PLAYERS*9  player i x offset from ORIGIN_X, bits [i*9 +: 9]
player_y  in  NUM_PLAYERS*9  player i y offset from ORIGIN_Y
player_direction  in  NUM_PLAYERS*2  0 left, 1 right, 2 up, 3 down
hcount  in  11  pixel x
vcount  in  10  pixel y
hsync, vsync, blank  in  1 each  XVGA timing (syncs active low)
hsync_out, vsync_out, blank_out  out  1 each  timing delayed 3 cycles
pixel_out  out  12  RGB444

Behaviour:
- Reset (reset=0, asynchronous): pixel_out=0, hsync_out=1, vsync_out=1, blank_out=1. All pipeline registers cleared. Shadow grids cleared to 0.
- Frame latch: vsync registered once. On its falling edge (1->0), shadow_obj<=object_grid and shadow_time<=time_grid in that cycle. Shadows hold for the whole frame, so mid-frame changes to the grid inputs are invisible until the next latch.
- Stage 1 (register): dx=hcount-ORIGIN_X and dy=vcount-ORIGIN_Y, 12-bit signed.
  - in_grid = dx>=0 && dy>=0 && col<GRID_COLS && row<GRID_ROWS, where col=dx>>TILE_LOG2 and row=dy>>TILE_LOG2.
  - Tile offsets ox/oy = low TILE_LOG2 bits of dx/dy. Timing signals delayed alongside.
- Stage 2 (register): fetch code and timer t from the shadows at (row,col).
  - tile_px:
    - ox==0 or oy==0 -> 12'h000 (border).
    - t!=0 and oy>=2^TILE_LOG2-4 and ox<(t<<(TILE_LOG2-4)) -> 12'h0F0 (timer bar).
    - otherwise palette[code].
  - palette: 0 666, 1 C6F, 2 E9F, 3 FFF, 4 FA4, 5 444, 6 A86, 7 A40, 8 F80, 9 F00, 10 D22, 11..15 F0F (error).
  - Player hit: player i active if i<num_players. Hit when 0<=dx-px_i<PLAYER_SIZE and 0<=dy-py_i<PLAYER_SIZE.
  - Player colour: local player FF0, others 0AF. The 4-pixel strip on the facing edge is F00.
  - On overlapping players, the lowest index wins.
- Stage 3 (register): pixel_out is chosen in priority order:
  - blank -> 0
  - game_state!=S_GAME -> 0
  - player hit -> player colour
  - in_grid -> tile_px
  - else background 12'h224
- Latency: pixel and all three timing outputs are exactly 3 clocks after the inputs, with no stalls and one pixel per clock.
- Reset deasserted mid-frame: shadows stay 0 (all cells render 666) until the next vsync falling edge.
- Arithmetic: player coordinates are unsigned 9-bit, compared in 12-bit signed space. A player extending beyond the grid is still drawn (not clipped to the grid).

Test Plan:
1. Assert reset mid-line with outputs active -> same cycle: pixel_out=0, hsync_out=vsync_out=blank_out=1; shadows read 0 after release.
2. Cell (row1,col2)=1, vsync pulse, game_state=1, hcount=181, vcount=149 -> 3 clocks later pixel_out=C6F. hcount=176 -> 000 (border). hcount=111 -> 224.
3. After latch, change object_grid cell (row1,col2) to 9 mid-frame -> pixel stays C6F until the next vsync falling edge, then F00.
4. time cell (row0,col0)=8, vcount=112+30 -> ox=15 gives 0F0, ox=16 gives palette colour; t=0 gives no bar.
5. num_players=2, local_player_ID=1, players 0 and 1 both at (0,0) facing right -> pixel (ORIGIN+5,ORIGIN+5)=0AF, (ORIGIN+14,ORIGIN+5)=F00. Player 2 at (40,40) -> not drawn.
6. blank=1 or game_state=0 over a populated cell -> pixel_out=0. hsync/vsync/blank edges appear on outputs exactly 3 clocks later.
